// File: rtl/mp_brentkung_seq.sv
// Multi-precision add sequencer: feeds a 64-bit Brent-Kung adder one word per cycle, LS word first.
// Optional macro MP_SUB_EN adds a 'sub' input for wide subtraction (a - b mod 2^W).

module sixty_four_bit_brentkung (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  // Carry-in is folded into bit 0's generate, so the prefix tree yields carry-out of every bit.
  // NOTE: blocking assignments here build combinational logic in order; each variable gets a value before any read, so no latch.
  always_comb begin : prefix
    logic [63:0] v_g;
    logic [63:0] v_p;
    v_g    = A & B;
    v_p    = A ^ B;
    v_g[0] = v_g[0] | (v_p[0] & cin);
    for (int l = 0; l < 6; l++) begin
      for (int i = (2 << l) - 1; i < 64; i += (2 << l)) begin
        v_g[6'(i)] = v_g[6'(i)] | (v_p[6'(i)] & v_g[6'(i - (1 << l))]);
        v_p[6'(i)] = v_p[6'(i)] & v_p[6'(i - (1 << l))];
      end
    end
    for (int l = 4; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < 64; i += (2 << l)) begin
        v_g[6'(i)] = v_g[6'(i)] | (v_p[6'(i)] & v_g[6'(i - (1 << l))]);
        v_p[6'(i)] = v_p[6'(i)] & v_p[6'(i - (1 << l))];
      end
    end
    sum  = (A ^ B) ^ {v_g[62:0], cin};
    cout = v_g[63];
  end

endmodule

module mp_brentkung_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*NWORDS-1:0] a,
  input  logic [64*NWORDS-1:0] b,
  input  logic                 cin,
`ifdef MP_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*NWORDS-1:0] sum,
  output logic                 cout
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NWORDS-1:0][63:0]      r_a;
  logic [NWORDS-1:0][63:0]      r_b;
  logic [NWORDS-1:0][63:0]      r_sum;
  logic [IDXW-1:0]              r_idx;
  logic                         r_carry;
  logic                         r_cout;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_carry_init;
  logic [63:0]                  w_b_word;
  logic [63:0]                  w_add_sum;
  logic                         w_add_cout;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_LAST);

`ifdef MP_SUB_EN
  logic r_sub;
  // Subtraction is a + ~b + 1, so the carry chain starts at 1 regardless of cin.
  assign w_carry_init = sub ? 1'b1 : cin;
  assign w_b_word     = r_sub ? ~r_b[r_idx] : r_b[r_idx];
`else
  assign w_carry_init = cin;
  assign w_b_word     = r_b[r_idx];
`endif

  sixty_four_bit_brentkung u_adder (
    .A    (r_a[r_idx]),
    .B    (w_b_word),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded before use, and skipping reset keeps them plain flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
`ifdef MP_SUB_EN
      r_sub <= sub;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_carry <= w_carry_init;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx] <= w_add_sum;
      r_carry      <= w_add_cout;
      if (w_last) begin
        r_cout <= w_add_cout;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDXW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_mp_brentkung_seq.sv
// Self-checking bench for mp_brentkung_seq (NWORDS=4): scoreboard of W-bit reference sums.
// Subtraction cases are compiled in when MP_SUB_EN is defined.

module tb_mp_brentkung_seq;

  localparam int NWORDS = 4;
  localparam int W      = 64 * NWORDS;

  typedef logic [W:0] res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  res_t exp_q[$];
  int   out_cyc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_brentkung_seq #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MP_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input res_t got, input res_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    return {1'b0, x} + {1'b0, yy} + res_t'(cc);
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Results are compared on the falling edge before the transferring rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("sb_underflow", res_t'(1), res_t'(0));
      else                   check("sb_result", {cout, sum}, exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns once out_valid is seen, also checking latency.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic s, input res_t e, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, res_t'(in_ready), res_t'(1));
      return;
    end
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~x; b = ~y; cin = ~c; sub = ~s;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, res_t'(n), res_t'(NWORDS));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", res_t'(exp_q.size()), res_t'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0] x, y;
    logic         c;
    logic [W-1:0] bx[3];
    logic [W-1:0] by[3];
    logic         bc[3];
    int           n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  res_t'(in_ready),  res_t'(1));
    check("rst_out_valid", res_t'(out_valid), res_t'(0));
    check("rst_result",    {cout, sum},       res_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    // Carry ripple and cin paths with hand-derived results.
    run_op('1, W'(1), 1'b0, 1'b0, {1'b1, {W{1'b0}}}, "ripple_all");
    run_op(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0, res_t'(1) << 64, "ripple_w0");
    run_op('0, '0, 1'b1, 1'b0, res_t'(1), "cin_one");
    run_op('1, '1, 1'b1, 1'b0, {1'b1, {W{1'b1}}}, "cin_all");
    drain();

    // Backpressure: result held for 5 cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    x = rand_w(); y = rand_w();
    run_op(x, y, 1'b0, 1'b0, ref_sum(x, y, 1'b0, 1'b0), "bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  res_t'(out_valid), res_t'(1));
      check("bp_ready",  res_t'(in_ready),  res_t'(0));
      check("bp_hold",   {cout, sum},       ref_sum(x, y, 1'b0, 1'b0));
      in_valid = (i < 3);
      a = rand_w(); b = rand_w();
      @(posedge clk); #1;
    end
    check("bp_valid_end", res_t'(out_valid), res_t'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", res_t'(out_valid), res_t'(0));
    check("bp_release_ready", res_t'(in_ready),  res_t'(1));
    check("bp_sb_empty",      res_t'(exp_q.size()), res_t'(0));

    // Back-to-back with in_valid held high.
    for (int k = 0; k < 3; k++) begin
      bx[k] = rand_w(); by[k] = rand_w(); bc[k] = 1'($urandom_range(0, 1));
    end
    out_cyc_q.delete();
    sub = 1'b0;
    in_valid = 1'b1;
    a = bx[0]; b = by[0]; cin = bc[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b_ready", res_t'(in_ready), res_t'(1));
      exp_q.push_back(ref_sum(bx[k], by[k], bc[k], 1'b0));
      @(posedge clk); #1;
      if (k < 2) begin
        a = bx[k+1]; b = by[k+1]; cin = bc[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    drain();
    check("b2b_count", res_t'(out_cyc_q.size()), res_t'(3));
    for (int k = 1; k < out_cyc_q.size(); k++)
      check("b2b_spacing", res_t'(out_cyc_q[k] - out_cyc_q[k-1]), res_t'(NWORDS + 2));

    // Random single operations.
    for (int k = 0; k < 4; k++) begin
      x = rand_w(); y = rand_w(); c = 1'($urandom_range(0, 1));
      run_op(x, y, c, 1'b0, ref_sum(x, y, c, 1'b0), "rand");
    end
    drain();

    // Asynchronous reset in the middle of RUN.
    a = '1; b = '1; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  res_t'(in_ready),  res_t'(1));
    check("arst_out_valid", res_t'(out_valid), res_t'(0));
    check("arst_result",    {cout, sum},       res_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    x = rand_w(); y = rand_w();
    run_op(x, y, 1'b1, 1'b0, ref_sum(x, y, 1'b1, 1'b0), "post_rst");
    drain();

`ifdef MP_SUB_EN
    run_op(W'(5), W'(7), 1'b0, 1'b1, {1'b0, {(W-1){1'b1}}, 1'b0}, "sub_neg");
    run_op(W'(7), W'(5), 1'b0, 1'b1, {1'b1, W'(2)}, "sub_pos");
    run_op(W'(7), W'(5), 1'b1, 1'b1, {1'b1, W'(2)}, "sub_cin_ignored");
    x = rand_w(); y = rand_w();
    run_op(x, y, 1'b0, 1'b1, ref_sum(x, y, 1'b0, 1'b1), "sub_rand");
    run_op(x, y, 1'b0, 1'b0, ref_sum(x, y, 1'b0, 1'b0), "sub_off");
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_brentkung_seq.md
Name: mp_brentkung_seq

Overview:
- Multi-precision add sequencer placed directly upstream of the 64-bit Brent-Kung adder (sixty_four_bit_brentkung: A, B, cin in; sum, cout out).
- Accepts wide operands over a valid/ready handshake and feeds the adder one 64-bit word per cycle, least-significant word first, chaining carry through a register.
- Collects the sum words and presents the wide result over a second valid/ready handshake.
- Single instance of the combinational adder; one internal carry register; no other arithmetic.

Parameters:
- NWORDS, 4, number of 64-bit words per operand; operand width W = 64*NWORDS; legal range 1..16.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in to word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  wide sum, registered.
- cout  output  1  carry-out of most-significant word, registered.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, word index=0, carry register=0.
- Reset mid-operation aborts the operation, discards partial results and returns to IDLE with the values above.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge: latch a, b; carry register <= cin; word index <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Adder inputs: A=a_reg word[idx], B=b_reg word[idx], cin=carry register.
  - Each edge: sum word[idx] <= adder sum; carry register <= adder cout; idx <= idx+1.
  - When idx==NWORDS-1: cout <= adder cout and go to DONE.
- DONE:
  - out_valid=1, in_ready=0; sum and cout held stable.
  - On out_ready at an edge: out_valid <= 0, go to IDLE.
- Latency: out_valid rises exactly NWORDS cycles after the accepting edge.
- Throughput: one operation per NWORDS+2 cycles minimum (accept, NWORDS run, handoff); no overlap of operations.
- Input and output handshakes:
  - a, b and cin are sampled only on the accepting edge; later changes have no effect.
  - in_valid asserted outside IDLE is ignored; no queueing.
  - out_ready held high in DONE: result leaves after 1 cycle of out_valid.
  - out_ready high outside DONE has no effect.
- Width rules:
  - Word k = bits [64k+63:64k].
  - Result is modulo 2^W; the carry out of the top word goes only to cout.
  - NWORDS=1 degenerates to one RUN cycle.
- Sum register bits are stable while out_valid=1 and change only during RUN.

Optional Feature:
- Macro MP_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with operands on the accepting edge.
  - sub=1: adder B input is the bitwise inverse of b_reg word[idx], and the carry register is initialised to 1 (cin ignored), giving sum = a - b mod 2^W.
  - cout=1 means no borrow (a >= b unsigned).
  - sub=0 behaves exactly as the base block.
- Undefined: port sub absent; addition only.

Test Plan (NWORDS=4):
- Reset: rst_n low asynchronously while in RUN -> in_ready=1, out_valid=0, sum=0, cout=0 immediately; next accepted operation correct.
- Carry ripple across words: a=2^256-1, b=1, cin=0 -> sum=0, cout=1, out_valid 4 cycles after accept; a=2^64-1, b=1 -> sum=2^64, cout=0.
- cin path: a=0, b=0, cin=1 -> sum=1, cout=0; a=b=2^256-1, cin=1 -> sum=2^256-1, cout=1.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid and sum stable; in_valid pulses ignored (in_ready=0); release -> one transfer, back to IDLE.
- Back-to-back: in_valid held with 3 operand sets, out_ready=1 -> results in order, each spaced NWORDS+2 cycles; random pairs checked against a W-bit reference sum.
- MP_SUB_EN: sub=1, a=5, b=7 -> sum=2^256-2, cout=0; a=7, b=5 -> sum=2, cout=1.
